// File: rtl/rvv_backend_alu_mask_arb.sv
// rtl/rvv_backend_alu_mask_arb.sv - round-robin share of the vm* mask-logic unit, issue stage and result FIFO to the ROB (optional MASK_ARB_PERF_CNT_EN)
module rvv_backend_alu_mask_arb #(
  parameter int NUM_REQ         = 2,
  parameter int FIFO_DEPTH      = 2,
  parameter int ROB_DEPTH_WIDTH = 3,
  parameter int VLEN            = 32,
  localparam int VSTART_W       = $clog2(VLEN) + 1,
  localparam int UOP_W          = ROB_DEPTH_WIDTH + 3 + VSTART_W + 1 + 3 * VLEN,
  localparam int RES_W          = ROB_DEPTH_WIDTH + 4 + VLEN
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                trap_flush,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][UOP_W-1:0]       req_uop,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                result_valid_ex2rob,
  output logic [RES_W-1:0]                    result_ex2rob,
  input  logic                                result_ready_rob2ex,
  output logic                                err_drop,
  output logic [ROB_DEPTH_WIDTH-1:0]          err_rob_entry
`ifdef MASK_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                         perf_grant_cnt,
  output logic [31:0]                         perf_stall_cnt
`endif
);

  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // funct6[2:0] of the OPMVV mask-logic group
  localparam logic [2:0] OP_VMANDN = 3'd0;
  localparam logic [2:0] OP_VMAND  = 3'd1;
  localparam logic [2:0] OP_VMOR   = 3'd2;
  localparam logic [2:0] OP_VMXOR  = 3'd3;
  localparam logic [2:0] OP_VMORN  = 3'd4;
  localparam logic [2:0] OP_VMNAND = 3'd5;
  localparam logic [2:0] OP_VMNOR  = 3'd6;
  localparam logic       W_VRF     = 1'b0;

  typedef struct packed {
    logic [ROB_DEPTH_WIDTH-1:0] rob_entry;
    logic [2:0]                 opcode;
    logic [VSTART_W-1:0]        vstart;
    logic                       vd_data_valid;
    logic [VLEN-1:0]            vd_data;
    logic [VLEN-1:0]            vs2_data;
    logic [VLEN-1:0]            vs1_data;
  } alu_rs_t;

  typedef struct packed {
    logic [ROB_DEPTH_WIDTH-1:0] rob_entry;
    logic                       w_valid;
    logic                       w_type;
    logic                       ignore_vta;
    logic                       ignore_vma;
    logic [VLEN-1:0]            w_data;
  } alu2rob_t;

  logic               stage_valid;
  alu_rs_t            stage_uop;
  logic [RR_W-1:0]    rr_ptr;
  logic [RR_W-1:0]    cand;
  logic [RR_W-1:0]    win_idx;
  logic               win_found;
  logic               space;
  logic               grant_any;
  logic [CNT_W-1:0]   fifo_count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [RES_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic               fifo_push;
  logic               fifo_pop;
  logic [VLEN-1:0]    op_res;
  logic [VLEN-1:0]    unit_data;
  logic               unit_valid;
  alu2rob_t           unit_res;

  // Occupancy counts registered state only; a pop this cycle does not free a slot yet.
  assign space = (fifo_count + CNT_W'(stage_valid)) < DEPTH_C;

  // Round-robin winner search starting at rr_ptr, then one-hot ready when there is room.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = RR_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    grant_any = win_found && space && !trap_flush && !rst;
    req_ready = '0;
    if (grant_any) req_ready[win_idx] = 1'b1;
  end

  // Arbitration pointer moves past the winner on every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (win_idx == RR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Issue stage register feeding the mask unit.
  always_ff @(posedge clk) begin
    if (rst || trap_flush) begin
      stage_valid <= 1'b0;
    end else begin
      stage_valid <= grant_any;
    end
    if (grant_any) stage_uop <= alu_rs_t'(req_uop[win_idx]);
  end

  // Mask-logic unit: bitwise op, prestart bits keep old vd, needs vd to produce a result.
  always_comb begin
    op_res = '0;
    case (stage_uop.opcode)
      OP_VMANDN: op_res = stage_uop.vs2_data & ~stage_uop.vs1_data;
      OP_VMAND:  op_res = stage_uop.vs2_data &  stage_uop.vs1_data;
      OP_VMOR:   op_res = stage_uop.vs2_data |  stage_uop.vs1_data;
      OP_VMXOR:  op_res = stage_uop.vs2_data ^  stage_uop.vs1_data;
      OP_VMORN:  op_res = stage_uop.vs2_data | ~stage_uop.vs1_data;
      OP_VMNAND: op_res = ~(stage_uop.vs2_data & stage_uop.vs1_data);
      OP_VMNOR:  op_res = ~(stage_uop.vs2_data | stage_uop.vs1_data);
      default:   op_res = ~(stage_uop.vs2_data ^ stage_uop.vs1_data);
    endcase
    unit_data = op_res;
    for (int i = 0; i < VLEN; i++) begin
      if (VSTART_W'(i) < stage_uop.vstart) unit_data[i] = stage_uop.vd_data[i];
    end
    unit_valid          = stage_valid && stage_uop.vd_data_valid;
    unit_res            = '0;
    unit_res.rob_entry  = stage_uop.rob_entry;
    unit_res.w_valid    = 1'b1;
    unit_res.w_type     = W_VRF;
    unit_res.ignore_vta = 1'b1;
    unit_res.ignore_vma = 1'b1;
    unit_res.w_data     = unit_data;
  end

  assign fifo_push           = unit_valid && !trap_flush;
  assign result_valid_ex2rob = (fifo_count != '0);
  assign fifo_pop            = result_valid_ex2rob && result_ready_rob2ex && !trap_flush;
  assign result_ex2rob       = result_valid_ex2rob ? fifo_mem[rd_ptr] : '0;

  // Result FIFO pointers and occupancy; flush empties it in one cycle.
  always_ff @(posedge clk) begin
    if (rst || trap_flush) begin
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (fifo_push && !fifo_pop)      fifo_count <= fifo_count + 1'b1;
      else if (!fifo_push && fifo_pop) fifo_count <= fifo_count - 1'b1;
    end
  end

  // Result FIFO storage, data only.
  always_ff @(posedge clk) begin
    if (fifo_push && !rst) fifo_mem[wr_ptr] <= unit_res;
  end

  // Report an issued uop the unit could not complete.
  always_ff @(posedge clk) begin
    if (rst || trap_flush) begin
      err_drop      <= 1'b0;
      err_rob_entry <= '0;
    end else begin
      err_drop      <= stage_valid && !unit_valid;
      err_rob_entry <= (stage_valid && !unit_valid) ? stage_uop.rob_entry : '0;
    end
  end

`ifdef ASSERT_ON
  // Space check at grant time should make an overflowing push unreachable.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(fifo_push && !fifo_pop && fifo_count == DEPTH_C));
  end
`endif

`ifdef MASK_ARB_PERF_CNT_EN
  // Saturating grant and stall counters, kept across trap_flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (grant_any && perf_grant_cnt != 32'hFFFF_FFFF)
        perf_grant_cnt <= perf_grant_cnt + 32'd1;
      if ((|req_valid) && !grant_any && perf_stall_cnt != 32'hFFFF_FFFF)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rvv_backend_alu_mask_arb.sv
// tb/tb_rvv_backend_alu_mask_arb.sv - directed self-checking bench for rvv_backend_alu_mask_arb
module tb_rvv_backend_alu_mask_arb;

  localparam int UOP_W = 109;
  localparam int RES_W = 39;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  trap_flush;
  logic [1:0]            req_valid;
  logic [1:0][UOP_W-1:0] req_uop;
  logic                  rob_ready;

  logic [1:0]            d_ready, d_ready4;
  logic                  d_rv, d_rv4;
  logic [RES_W-1:0]      d_res, d_res4;
  logic                  d_err, d_err4;
  logic [2:0]            d_err_rob, d_err_rob4;

  int n_checks = 0;
  int n_fail   = 0;
  int grants;

  always #5 clk = ~clk;

  rvv_backend_alu_mask_arb #(.NUM_REQ(2), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .trap_flush(trap_flush),
    .req_valid(req_valid), .req_uop(req_uop), .req_ready(d_ready),
    .result_valid_ex2rob(d_rv), .result_ex2rob(d_res), .result_ready_rob2ex(rob_ready),
    .err_drop(d_err), .err_rob_entry(d_err_rob)
  );

  rvv_backend_alu_mask_arb #(.NUM_REQ(2), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .trap_flush(trap_flush),
    .req_valid(req_valid), .req_uop(req_uop), .req_ready(d_ready4),
    .result_valid_ex2rob(d_rv4), .result_ex2rob(d_res4), .result_ready_rob2ex(rob_ready),
    .err_drop(d_err4), .err_rob_entry(d_err_rob4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [UOP_W-1:0] mk_uop(input logic [2:0] rob, input logic [2:0] op,
      input logic vdv, input logic [31:0] vd, input logic [31:0] vs2, input logic [31:0] vs1);
    return {rob, op, 6'd0, vdv, vd, vs2, vs1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; trap_flush = 1'b0; req_valid = 2'b00; rob_ready = 1'b0;
    req_uop = '0;
    tick(); tick();
    req_valid = 2'b11;
    #1;
    check_eq("rst_ready", 64'(d_ready), 64'h0);
    check_eq("rst_rv", 64'(d_rv), 64'h0);
    check_eq("rst_res", 64'(d_res), 64'h0);
    check_eq("rst_err", 64'(d_err), 64'h0);
    check_eq("rst_err_rob", 64'(d_err_rob), 64'h0);
    req_valid = 2'b00;
    rst = 1'b0;
    tick();

    // single VMAND
    rob_ready = 1'b1;
    req_uop[0] = mk_uop(3'd1, 3'd1, 1'b1, 32'h0, 32'h0000_F0F0, 32'h0000_FF00);
    req_valid = 2'b01;
    #1;
    check_eq("t1_ready", 64'(d_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    #1;
    check_eq("t1_rv_n1", 64'(d_rv), 64'h0);
    tick();
    check_eq("t1_rv_n2", 64'(d_rv), 64'h1);
    check_eq("t1_data", 64'(d_res[31:0]), 64'h0000_F000);
    check_eq("t1_wtype", 64'(d_res[34]), 64'h0);
    check_eq("t1_vta", 64'(d_res[33]), 64'h1);
    check_eq("t1_rob", 64'(d_res[38:36]), 64'h1);
    tick();
    check_eq("t1_rv_pop", 64'(d_rv), 64'h0);

    // round-robin, sustained throughput on the deeper instance
    do_reset();
    req_uop[0] = mk_uop(3'd2, 3'd3, 1'b1, 32'h0, 32'h1234_5678, 32'hFFFF_0000);
    req_uop[1] = mk_uop(3'd3, 3'd2, 1'b1, 32'h0, 32'h0000_00F0, 32'h0000_000F);
    req_valid = 2'b11;
    rob_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check_eq($sformatf("t2_ready_c%0d", c), 64'(d_ready4), (c % 2 == 0) ? 64'h1 : 64'h2);
      if (c >= 2) begin
        check_eq($sformatf("t2_rv_c%0d", c), 64'(d_rv4), 64'h1);
        check_eq($sformatf("t2_rob_c%0d", c), 64'(d_res4[38:36]), (c % 2 == 0) ? 64'h2 : 64'h3);
        check_eq($sformatf("t2_data_c%0d", c), 64'(d_res4[31:0]),
                 (c % 2 == 0) ? 64'hEDCB_5678 : 64'h0000_00FF);
      end
      tick();
    end
    req_valid = 2'b00;
    repeat (4) tick();

    // backpressure, depth 2
    do_reset();
    rob_ready = 1'b0;
    req_uop[0] = mk_uop(3'd4, 3'd1, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0000_00AA);
    req_valid = 2'b01;
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (d_ready[0]) grants++;
      tick();
    end
    check_eq("t3_grants", 64'(grants), 64'd2);
    check_eq("t3_ready_full", 64'(d_ready), 64'h0);
    check_eq("t3_head_valid", 64'(d_rv), 64'h1);
    check_eq("t3_head_rob", 64'(d_res[38:36]), 64'h4);
    check_eq("t3_head_data", 64'(d_res[31:0]), 64'h0000_00AA);
    rob_ready = 1'b1;
    tick();
    rob_ready = 1'b0;
    #1;
    check_eq("t3_regrant", 64'(d_ready), 64'h1);
    tick();
    check_eq("t3_full_again", 64'(d_ready), 64'h0);
    req_valid = 2'b00;

    // drop: VMOR without old vd
    do_reset();
    rob_ready = 1'b1;
    req_uop[0] = mk_uop(3'd5, 3'd2, 1'b0, 32'h0, 32'h1, 32'h2);
    req_valid = 2'b01;
    #1;
    check_eq("t4_ready", 64'(d_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    check_eq("t4_err_early", 64'(d_err), 64'h0);
    tick();
    check_eq("t4_err", 64'(d_err), 64'h1);
    check_eq("t4_err_rob", 64'(d_err_rob), 64'h5);
    check_eq("t4_no_push", 64'(d_rv), 64'h0);
    tick();
    check_eq("t4_err_pulse", 64'(d_err), 64'h0);

    // flush with 2 results queued and the stage busy (depth 4 instance)
    do_reset();
    rob_ready = 1'b0;
    req_uop[0] = mk_uop(3'd6, 3'd1, 1'b1, 32'h0, 32'hF, 32'hF);
    req_uop[1] = mk_uop(3'd7, 3'd1, 1'b1, 32'h0, 32'hF, 32'hF);
    req_valid = 2'b01;
    tick(); tick(); tick();
    req_valid = 2'b00;
    check_eq("t5_pre_count", 64'(u_dut4.fifo_count), 64'd2);
    check_eq("t5_pre_stage", 64'(u_dut4.stage_valid), 64'h1);
    trap_flush = 1'b1;
    req_valid = 2'b10;
    #1;
    check_eq("t5_no_grant", 64'(d_ready4), 64'h0);
    tick();
    trap_flush = 1'b0;
    req_valid = 2'b00;
    check_eq("t5_rv", 64'(d_rv4), 64'h0);
    check_eq("t5_count", 64'(u_dut4.fifo_count), 64'd0);
    check_eq("t5_err", 64'(d_err4), 64'h0);
    tick();
    check_eq("t5_rv_after", 64'(d_rv4), 64'h0);
    req_valid = 2'b11;
    #1;
    check_eq("t5_rr_hold", 64'(d_ready4), 64'h2);
    tick();
    req_valid = 2'b00;

    // reset mid-stream
    do_reset();
    rob_ready = 1'b0;
    req_uop[0] = mk_uop(3'd7, 3'd1, 1'b1, 32'h0, 32'h3, 32'h1);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    check_eq("t6_pre_rv", 64'(d_rv), 64'h1);
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    check_eq("t6_ready_in_rst", 64'(d_ready), 64'h0);
    tick();
    check_eq("t6_rv", 64'(d_rv), 64'h0);
    check_eq("t6_res", 64'(d_res), 64'h0);
    check_eq("t6_err", 64'(d_err), 64'h0);
    check_eq("t6_err_rob", 64'(d_err_rob), 64'h0);
    rst = 1'b0;
    #1;
    check_eq("t6_first_grant", 64'(d_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
